fixed_point_accumulator: RTL and testbench
==========================================

# fixed_point_accumulator

Sequential accumulator directly downstream of the 16-bit signed fixed-point multiplier in the ODE datapath. It sums a command-specified number of multiplier products (e.g. h·f terms) onto an initial value (e.g. xₙ), with guard bits and output saturation. It returns one 16-bit result plus a sticky overflow flag that also carries any per-term multiplier overflow. Format throughout is signed Q8.7: 16 bits, 7 fractional bits, so 1.0 = 0x0080.

## Interface
- `WIDTH`, 16: data width, signed Q8.7.
- `CNT_W`, 8: width of `term_count`.
- `GUARD`, 8: extra accumulator MSBs. Must satisfy `GUARD >= CNT_W`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: command strobe. Sampled only in IDLE.
- `term_count` in CNT_W: number of terms to accept, 0..2^CNT_W−1. Sampled with `start`.
- `init_value` in WIDTH: signed starting value. Sampled with `start`.
- `in_valid` in 1: term available.
- `in_data` in WIDTH: signed product term.
- `in_ovf` in 1: multiplier overflow flag for this term.
- `in_ready` out 1: block can accept a term.
- `out_valid` out 1: result available.
- `out_data` out WIDTH: saturated result.
- `out_overflow` out 1: overflow occurred during this command.
- `out_ready` in 1: consumer accepts the result.
- `busy` out 1: high when state ≠ IDLE.

## Operation
- Accumulator `acc` is signed, WIDTH+GUARD bits wide. Every operand is sign-extended to that width. With `GUARD >= CNT_W` the accumulator never wraps internally.
- States are IDLE, ACCUM and DONE.
- **IDLE**
  - On `start`: `acc` ← sext(`init_value`), `cnt` ← `term_count`, `ovf_sticky` ← 0.
  - If `term_count` == 0, go to DONE; otherwise go to ACCUM.
  - `in_ready` = 0.
- **ACCUM**
  - `in_ready` = 1.
  - On a term handshake (`in_valid` && `in_ready`): `acc` += sext(`in_data`), `ovf_sticky` |= `in_ovf`, `cnt` −= 1.
  - The handshake with `cnt` == 1 moves the block to DONE.
  - Cycles without `in_valid` leave all state unchanged.
- **DONE**
  - `out_valid` = 1.
  - `out_data` = sat(`acc`): 0x7FFF if `acc` > 32767, 0x8000 if `acc` < −32768, else `acc`[15:0].
  - `out_overflow` = `ovf_sticky` | (saturation applied).
  - On `out_ready`, go to IDLE.
- `start` outside IDLE is ignored and not queued.
- `out_data` and `out_overflow` hold their values until the next result is loaded.
- Result values are never rounded or truncated; saturation is the only narrowing.

## Timing
- Reset values: state IDLE; `in_ready`, `out_valid`, `out_overflow`, `busy` all 0; `out_data` 0x0000; `acc`, `cnt`, `ovf_sticky` all 0.
- `in_ready`, `out_valid` and `busy` are decodes of the state register, with no combinational path from inputs.
- All other outputs are registered.
- Latency:
  - `busy` rises the cycle after `start`.
  - `out_valid` rises the cycle after the last term handshake.
  - With `term_count` == 0, `out_valid` rises the cycle after `start`.
- Peak throughput is one term per cycle in ACCUM.
- Output handshake completes on a cycle with `out_valid` && `out_ready`. `busy` and `out_valid` are low the next cycle. The earliest new `start` is accepted in that next cycle.
- `rst` asserted in any state returns to IDLE on the next edge. Any partial sum is discarded and no `out_valid` is produced.
- `in_valid` asserted while not in ACCUM is ignored; no term is consumed.

## Structure
- Package `fxp_pkg` holds:
  - constants `FXP_WIDTH` = 16 and `FXP_FRAC` = 7;
  - the state enum (IDLE, ACCUM, DONE);
  - saturate bounds `FXP_MAX` = 0x7FFF and `FXP_MIN` = 0x8000.
- The multiplier and later datapath stages also use `fxp_pkg`.
- One combinational sub-module, `fxp_saturate`, narrows WIDTH+GUARD to WIDTH and flags saturation. It is reused by other narrowing stages.
- The FSM, counter and accumulator registers live in the top module.

## Test plan
- Init 0x0100 (2.0), count 3, terms 0x0080, 0x0040, 0xFFC0 sent back-to-back → `out_data` 0x0180 (3.0), `out_overflow` 0, `out_valid` one cycle after the 3rd handshake.
- Count 0, init 0x1234 → `out_valid` the cycle after `start`, `out_data` 0x1234, no `in_ready` pulse.
- Init 0x7000, count 2, terms 0x7000, 0x7000 (sum 0x15000) → `out_data` 0x7FFF, `out_overflow` 1. Mirror case: init 0x9000 with two terms 0x9000 → 0x8000, `out_overflow` 1.
- Init 0x7FFF, terms 0x7FFF, 0x8001 (transient above range) → `out_data` 0x7FFF, `out_overflow` 0; guard bits prevent false saturation.
- Count 4, `in_ovf` = 1 on term 2, small values summing to 0x0010, `in_valid` with 2-cycle gaps → `out_data` 0x0010, `out_overflow` 1. Then hold `out_ready` low 5 cycles while pulsing `start` → `out_data` stable, `start` ignored, IDLE on the first `out_ready`.
- `rst` pulsed after 2 of 5 terms → `in_ready`/`busy` 0 next cycle, no `out_valid`. A fresh command afterwards computes correctly from its own `init_value`.

Source files
------------

// File: rtl/fxp_pkg.sv
// Shared fixed-point definitions for the ODE datapath (signed Q8.7).
package fxp_pkg;

    localparam int FXP_WIDTH = 16;
    localparam int FXP_FRAC  = 7;

    localparam logic [FXP_WIDTH-1:0] FXP_MAX = 16'h7FFF;
    localparam logic [FXP_WIDTH-1:0] FXP_MIN = 16'h8000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } acc_state_e;

endpackage

// File: rtl/fixed_point_accumulator_if.sv
// Command, term and result signals of the fixed-point accumulator.
interface fixed_point_accumulator_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] term_count;
    logic [WIDTH-1:0] init_value;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ovf;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_overflow;
    logic             out_ready;
    logic             busy;

    modport master (
        output start, term_count, init_value, in_valid, in_data, in_ovf, out_ready,
        input  in_ready, out_valid, out_data, out_overflow, busy
    );

    modport slave (
        input  start, term_count, init_value, in_valid, in_data, in_ovf, out_ready,
        output in_ready, out_valid, out_data, out_overflow, busy
    );
endinterface

// File: rtl/fxp_saturate.sv
// Narrows a signed IN_W value to OUT_W bits, clamping to the signed range.
// Latency: combinational.
// Backpressure: none, pure function of din.
module fxp_saturate #(
    parameter int IN_W  = 24,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  din,
    output logic        [OUT_W-1:0] dout,
    output logic                    sat
);
    localparam int HI_W = IN_W - OUT_W + 1;

    // The value fits iff every bit from the output sign bit upward agrees.
    logic [HI_W-1:0] hi;

    always_comb begin
        hi   = din[IN_W-1:OUT_W-1];
        sat  = 1'b0;
        dout = din[OUT_W-1:0];
        if (!((&hi) || !(|hi))) begin
            sat  = 1'b1;
            dout = din[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                               : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
endmodule

// File: rtl/fixed_point_accumulator.sv
// Sums term_count signed Q8.7 terms onto init_value with guard bits, saturating the result.
// Latency: result valid the cycle after the last term (or after start when term_count is 0).
// Backpressure: one term per cycle in ACCUM; result held in DONE until out_ready.
module fixed_point_accumulator
    import fxp_pkg::*;
#(
    parameter int WIDTH = FXP_WIDTH,
    parameter int CNT_W = 8,
    parameter int GUARD = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    fixed_point_accumulator_if.slave  bus
);
    // GUARD >= CNT_W keeps the widest possible sum inside the accumulator.
    localparam int ACC_W = WIDTH + GUARD;

    acc_state_e              state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;
    logic                    load_result;
    logic [WIDTH-1:0]        out_data_q;
    logic                    out_ovf_q;
    logic [WIDTH-1:0]        sat_data;
    logic                    sat_flag;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        load_result = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    acc_d = {{GUARD{bus.init_value[WIDTH-1]}}, bus.init_value};
                    cnt_d = bus.term_count;
                    ovf_d = 1'b0;
                    if (bus.term_count == '0) begin
                        state_d     = ST_DONE;
                        load_result = 1'b1;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_ACCUM: begin
                if (bus.in_valid) begin
                    acc_d = acc_q + {{GUARD{bus.in_data[WIDTH-1]}}, bus.in_data};
                    ovf_d = ovf_q | bus.in_ovf;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d     = ST_DONE;
                        load_result = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Saturating the next-state sum lets the result register load as DONE is entered.
    fxp_saturate #(
        .IN_W  (ACC_W),
        .OUT_W (WIDTH)
    ) u_sat (
        .din  (acc_d),
        .dout (sat_data),
        .sat  (sat_flag)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            if (load_result) begin
                out_data_q <= sat_data;
                out_ovf_q  <= ovf_d | sat_flag;
            end
        end
    end

    assign bus.in_ready     = (state_q == ST_ACCUM);
    assign bus.out_valid    = (state_q == ST_DONE);
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.out_data     = out_data_q;
    assign bus.out_overflow = out_ovf_q;

endmodule

// File: tb/tb_fixed_point_accumulator.sv
// Bench for fixed_point_accumulator: directed vector table, corner sequences, randomized commands.
module tb_fixed_point_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fixed_point_accumulator_if #(.WIDTH(16), .CNT_W(8)) bus ();

    fixed_point_accumulator #(.WIDTH(16), .CNT_W(8), .GUARD(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       name;
        logic [15:0] init;
        int          cnt;
        logic [15:0] t [4];
        bit          o [4];
        int          gap;
        bit          hold;
        logic [15:0] ed;
        bit          eo;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer sum of all operands, then clamp to signed 16 bits.
    function automatic void model(input logic [15:0] init, input logic [15:0] t[$], input bit o[$],
                                  output logic [15:0] d, output bit ov);
        longint s;
        bit     any;
        s   = longint'($signed(init));
        any = 1'b0;
        foreach (t[i]) begin
            s   = s + longint'($signed(t[i]));
            any = any | o[i];
        end
        if (s > 32767) begin
            d = 16'h7FFF; ov = 1'b1;
        end else if (s < -32768) begin
            d = 16'h8000; ov = 1'b1;
        end else begin
            d = s[15:0]; ov = any;
        end
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge where out_valid must be high.
    task automatic run_cmd(input string name, input logic [15:0] init, input int cnt,
                           input logic [15:0] t[$], input bit o[$], input int gap,
                           input logic [15:0] ed, input bit eo);
        bus.start      = 1'b1;
        bus.init_value = init;
        bus.term_count = 8'(cnt);
        @(negedge clk);
        bus.start      = 1'b0;
        bus.init_value = 16'($urandom);
        bus.term_count = 8'($urandom);
        if (cnt == 0) begin
            chk({name, "/no_in_ready"}, 32'(bus.in_ready), 0);
        end else begin
            chk({name, "/busy_rise"}, 32'(bus.busy), 1);
            chk({name, "/early_valid"}, 32'(bus.out_valid), 0);
            for (int i = 0; i < cnt; i++) begin
                int g;
                g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
                repeat (g) @(negedge clk);
                if (i == 0 || g > 0) chk({name, "/in_ready"}, 32'(bus.in_ready), 1);
                bus.in_valid = 1'b1;
                bus.in_data  = t[i];
                bus.in_ovf   = o[i];
                @(negedge clk);
                bus.in_valid = 1'b0;
                bus.in_ovf   = 1'b0;
                bus.in_data  = 16'($urandom);
                if (i < cnt - 1) chk({name, "/valid_too_soon"}, 32'(bus.out_valid), 0);
            end
        end
        chk({name, "/out_valid"}, 32'(bus.out_valid), 1);
        chk({name, "/in_ready_done"}, 32'(bus.in_ready), 0);
        chk({name, "/out_data"}, 32'(bus.out_data), 32'(ed));
        chk({name, "/out_overflow"}, 32'(bus.out_overflow), 32'(eo));
    endtask

    task automatic release_out(input string name);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({name, "/valid_drop"}, 32'(bus.out_valid), 0);
        chk({name, "/busy_drop"}, 32'(bus.busy), 0);
    endtask

    task automatic hold_seq(input string name, input logic [15:0] ed, input bit eo);
        for (int k = 0; k < 5; k++) begin
            bus.start      = (k % 2) == 0;
            bus.init_value = 16'h5555;
            bus.term_count = 8'd1;
            @(negedge clk);
            chk({name, "/hold_valid"}, 32'(bus.out_valid), 1);
            chk({name, "/hold_data"}, 32'(bus.out_data), 32'(ed));
            chk({name, "/hold_ovf"}, 32'(bus.out_overflow), 32'(eo));
        end
        bus.start = 1'b0;
        release_out(name);
        @(negedge clk);
        chk({name, "/start_not_queued"}, 32'(bus.busy), 0);
        chk({name, "/data_kept"}, 32'(bus.out_data), 32'(ed));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [7];
        logic [15:0] tq [$];
        bit          oq [$];
        logic [15:0] ed;
        bit          eo;

        vecs[0] = '{"basic3",   16'h0100, 3, '{16'h0080, 16'h0040, 16'hFFC0, 16'h0}, '{0,0,0,0}, 0, 0, 16'h0180, 1'b0};
        vecs[1] = '{"zero_cnt", 16'h1234, 0, '{16'h0, 16'h0, 16'h0, 16'h0},         '{0,0,0,0}, 0, 0, 16'h1234, 1'b0};
        vecs[2] = '{"sat_pos",  16'h7000, 2, '{16'h7000, 16'h7000, 16'h0, 16'h0},   '{0,0,0,0}, 0, 0, 16'h7FFF, 1'b1};
        vecs[3] = '{"sat_neg",  16'h9000, 2, '{16'h9000, 16'h9000, 16'h0, 16'h0},   '{0,0,0,0}, 0, 0, 16'h8000, 1'b1};
        vecs[4] = '{"guard",    16'h7FFF, 2, '{16'h7FFF, 16'h8001, 16'h0, 16'h0},   '{0,0,0,0}, 0, 0, 16'h7FFF, 1'b0};
        vecs[5] = '{"gap_ovf",  16'h0000, 4, '{16'h0004, 16'h0004, 16'h0004, 16'h0004}, '{0,1,0,0}, 2, 1, 16'h0010, 1'b1};
        vecs[6] = '{"neg_mix",  16'hFF00, 2, '{16'h0040, 16'hFFC0, 16'h0, 16'h0},   '{0,0,0,0}, 1, 0, 16'hFF00, 1'b0};

        bus.start = 1'b0; bus.term_count = '0; bus.init_value = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_ovf = 1'b0; bus.out_ready = 1'b0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset/in_ready", 32'(bus.in_ready), 0);
        chk("reset/out_valid", 32'(bus.out_valid), 0);
        chk("reset/busy", 32'(bus.busy), 0);
        chk("reset/out_overflow", 32'(bus.out_overflow), 0);
        chk("reset/out_data", 32'(bus.out_data), 0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[v]) begin
            tq.delete(); oq.delete();
            for (int i = 0; i < vecs[v].cnt; i++) begin
                tq.push_back(vecs[v].t[i]);
                oq.push_back(vecs[v].o[i]);
            end
            run_cmd(vecs[v].name, vecs[v].init, vecs[v].cnt, tq, oq, vecs[v].gap, vecs[v].ed, vecs[v].eo);
            if (vecs[v].hold) hold_seq(vecs[v].name, vecs[v].ed, vecs[v].eo);
            else release_out(vecs[v].name);
        end

        // Full-length commands: the widest sums must not wrap the accumulator.
        tq.delete(); oq.delete();
        for (int i = 0; i < 255; i++) begin tq.push_back(16'h8000); oq.push_back(1'b0); end
        run_cmd("max_neg255", 16'h8000, 255, tq, oq, 0, 16'h8000, 1'b1);
        release_out("max_neg255");
        tq.delete(); oq.delete();
        for (int i = 0; i < 127; i++) begin tq.push_back(16'h7FFF); oq.push_back(1'b0); end
        for (int i = 0; i < 127; i++) begin tq.push_back(16'h8001); oq.push_back(1'b0); end
        tq.push_back(16'h0000); oq.push_back(1'b0);
        run_cmd("cancel255", 16'h0000, 255, tq, oq, 0, 16'h0000, 1'b0);
        release_out("cancel255");

        // Reset partway through a five-term command.
        bus.start = 1'b1; bus.init_value = 16'h0100; bus.term_count = 8'd5;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 16'h0300; bus.in_ovf = 1'b1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0; bus.in_ovf = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid/in_ready", 32'(bus.in_ready), 0);
        chk("rst_mid/busy", 32'(bus.busy), 0);
        chk("rst_mid/out_valid", 32'(bus.out_valid), 0);
        chk("rst_mid/out_data", 32'(bus.out_data), 0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_mid/no_valid", 32'(bus.out_valid), 0);
        end
        tq.delete(); oq.delete();
        tq.push_back(16'h0080); oq.push_back(1'b0);
        run_cmd("after_rst", 16'h0200, 1, tq, oq, 0, 16'h0280, 1'b0);
        release_out("after_rst");

        // Randomized commands against the reference model, with stray in_valid while idle.
        for (int n = 0; n < 40; n++) begin
            int cnt;
            int mode;
            logic [15:0] init;
            cnt  = int'($urandom_range(0, 7));
            mode = int'($urandom_range(0, 2));
            init = (mode == 0) ? 16'($urandom_range(0, 1023)) - 16'd512 : 16'($urandom);
            tq.delete(); oq.delete();
            for (int i = 0; i < cnt; i++) begin
                tq.push_back((mode == 0) ? 16'($urandom_range(0, 511)) - 16'd256 : 16'($urandom));
                oq.push_back($urandom_range(0, 7) == 0);
            end
            model(init, tq, oq, ed, eo);
            bus.in_valid = 1'b1; bus.in_data = 16'($urandom); bus.in_ovf = 1'b1;
            @(negedge clk);
            bus.in_valid = 1'b0; bus.in_ovf = 1'b0;
            chk("rand/idle_ignores_term", 32'(bus.busy), 0);
            run_cmd("rand", init, cnt, tq, oq, -1, ed, eo);
            release_out("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
